// File: rtl/ddr_axi_burst_master.sv
// ddr_axi_burst_master: AXI burst initiator for the ddr3 user port.
// Writes an address/beat pattern, reads it back and counts mismatches.
module ddr_axi_burst_master #(
  parameter int   CTRL_ADDR_WIDTH = 28,
  parameter int   AXI_DW          = 256,
  parameter logic AP              = 1'b1,
  parameter int   TIMEOUT         = 1023
) (
  input  logic                       core_clk,
  input  logic                       resetn,
  input  logic                       ddr_init_done,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [CTRL_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]                 cmd_len,
  input  logic [3:0]                 cmd_id,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [3:0]                 axi_awlen,
  output logic [3:0]                 axi_awuser_id,
  output logic                       axi_awuser_ap,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [AXI_DW-1:0]          axi_wdata,
  output logic [AXI_DW/8-1:0]        axi_wstrb,
  input  logic                       axi_wready,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]                 axi_arlen,
  output logic [3:0]                 axi_aruser_id,
  output logic                       axi_aruser_ap,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,
  input  logic [AXI_DW-1:0]          axi_rdata,
  input  logic [3:0]                 axi_rid,
  input  logic                       axi_rlast,
  input  logic                       axi_rvalid,
  output logic                       done,
  output logic [15:0]                err_cnt,
  output logic                       timeout
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [CTRL_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  id_q;
  logic [3:0]  beat_q;
  logic [TW-1:0] to_cnt_q;
  logic        cmd_ready_q;
  logic        done_q;
  logic        timeout_q;
  logic [15:0] err_q;

  logic        cmd_hs;
  logic        last_beat;
  logic        progress;
  logic        to_hit;
  logic        beat_adv;
  logic        rd_err;
  logic [31:0] word;
  logic [AXI_DW-1:0] pat;

  assign cmd_hs    = cmd_valid && cmd_ready_q;
  assign last_beat = (beat_q == len_q);
  assign word      = 32'(addr_q) + 32'(beat_q);
  assign pat       = {(AXI_DW/32){word}};

  always_comb begin
    progress = 1'b0;
    beat_adv = 1'b0;
    unique case (state_q)
      WR_ADDR: progress = axi_awready;
      RD_ADDR: progress = axi_arready;
      WR_DATA: begin
        progress = axi_wready;
        beat_adv = axi_wready;
      end
      RD_DATA: begin
        progress = axi_rvalid;
        beat_adv = axi_rvalid;
      end
      default: ;
    endcase
  end

  // Abort once the counter would reach TIMEOUT with no progress this cycle.
  assign to_hit = (state_q != IDLE) && !progress
               && (to_cnt_q == TO_LAST);

  assign rd_err = (state_q == RD_DATA) && axi_rvalid
               && ((axi_rdata != pat)
                || (axi_rid != id_q)
                || (axi_rlast != last_beat));

  always_ff @(posedge core_clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (cmd_hs) state_d = cmd_write ? WR_ADDR : RD_ADDR;
      WR_ADDR:
        if (axi_awready) state_d = WR_DATA;
      WR_DATA:
        if (axi_wready && last_beat) state_d = IDLE;
      RD_ADDR:
        if (axi_arready) state_d = RD_DATA;
      RD_DATA:
        if (axi_rvalid && (axi_rlast || last_beat)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_hit) state_d = IDLE;
  end

  always_comb begin
    axi_awvalid   = (state_q == WR_ADDR);
    axi_arvalid   = (state_q == RD_ADDR);
    axi_awaddr    = addr_q;
    axi_awlen     = len_q;
    axi_awuser_id = id_q;
    axi_awuser_ap = AP;
    axi_araddr    = addr_q;
    axi_arlen     = len_q;
    axi_aruser_id = id_q;
    axi_aruser_ap = AP;
    axi_wdata     = pat;
    axi_wstrb     = '1;
    cmd_ready     = cmd_ready_q;
    done          = done_q;
    timeout       = timeout_q;
    err_cnt       = err_q;
  end

  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      beat_q      <= '0;
      to_cnt_q    <= '0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      cmd_ready_q <= ddr_init_done && (state_d == IDLE);
      done_q      <= (state_q != IDLE) && (state_d == IDLE);
      timeout_q   <= timeout_q | to_hit;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        id_q   <= cmd_id;
        beat_q <= '0;
      end else if (beat_adv) begin
        beat_q <= beat_q + 4'd1;
      end
      if ((state_d != state_q) || progress)
        to_cnt_q <= '0;
      else if (state_q != IDLE)
        to_cnt_q <= to_cnt_q + 1'b1;
      if (rd_err && (err_q != 16'hFFFF))
        err_q <= err_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// tb_ddr_axi_burst_master: directed vector bench for the burst master.
// Table of write/read bursts plus hand sequences for init, timeout, reset.
module tb_ddr_axi_burst_master;

  localparam int CAW = 28;
  localparam int DW  = 256;
  localparam int TO  = 15;

  logic           core_clk = 1'b0;
  logic           resetn = 1'b0;
  logic           ddr_init_done = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_write = 1'b0;
  logic [CAW-1:0] cmd_addr = '0;
  logic [3:0]     cmd_len = '0;
  logic [3:0]     cmd_id = '0;
  logic [CAW-1:0] axi_awaddr;
  logic [3:0]     axi_awlen;
  logic [3:0]     axi_awuser_id;
  logic           axi_awuser_ap;
  logic           axi_awvalid;
  logic           axi_awready = 1'b0;
  logic [DW-1:0]  axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic           axi_wready = 1'b0;
  logic [CAW-1:0] axi_araddr;
  logic [3:0]     axi_arlen;
  logic [3:0]     axi_aruser_id;
  logic           axi_aruser_ap;
  logic           axi_arvalid;
  logic           axi_arready = 1'b0;
  logic [DW-1:0]  axi_rdata = '0;
  logic [3:0]     axi_rid = '0;
  logic           axi_rlast = 1'b0;
  logic           axi_rvalid = 1'b0;
  logic           done;
  logic [15:0]    err_cnt;
  logic           timeout;

  ddr_axi_burst_master #(
    .CTRL_ADDR_WIDTH(CAW),
    .AXI_DW(DW),
    .AP(1'b1),
    .TIMEOUT(TO)
  ) dut (
    .core_clk(core_clk),
    .resetn(resetn),
    .ddr_init_done(ddr_init_done),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .cmd_id(cmd_id),
    .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen),
    .axi_awuser_id(axi_awuser_id),
    .axi_awuser_ap(axi_awuser_ap),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb),
    .axi_wready(axi_wready),
    .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen),
    .axi_aruser_id(axi_aruser_id),
    .axi_aruser_ap(axi_aruser_ap),
    .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata),
    .axi_rid(axi_rid),
    .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid),
    .done(done),
    .err_cnt(err_cnt),
    .timeout(timeout)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    int          aw_dly;
    logic [3:0]  rid;
    int          bad;
    bit          no_rlast;
    int          dlt;
    logic [31:0] w0;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [27:0] a,
                       input logic [3:0] l, input logic [3:0] i);
    int n;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_id    = i;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge core_clk);
      n++;
    end
    chk("cmd_accept_bound", 256'(n < 50), 256'(1));
    @(negedge core_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] w;
    issue(v.wr, v.addr, v.len, v.id);
    if (v.wr) begin
      chk("awvalid", 256'(axi_awvalid), 256'(1));
      chk("awaddr", 256'(axi_awaddr), 256'(v.addr));
      chk("awlen", 256'(axi_awlen), 256'(v.len));
      chk("awid", 256'(axi_awuser_id), 256'(v.id));
      chk("awap", 256'(axi_awuser_ap), 256'(1));
      axi_wready = 1'b1;
      repeat (v.aw_dly) @(negedge core_clk);
      chk("awvalid_hold", 256'(axi_awvalid), 256'(1));
      axi_awready = 1'b1;
      @(negedge core_clk);
      axi_awready = 1'b0;
      chk("wstrb", 256'(axi_wstrb), 256'({32{1'b1}}));
      for (int k = 0; k <= int'(v.len); k++) begin
        w = v.w0 + 32'(k);
        chk("wdata", axi_wdata, {8{w}});
        @(negedge core_clk);
      end
      axi_wready = 1'b0;
      chk("wr_done", 256'(done), 256'(1));
      chk("wr_awvalid_low", 256'(axi_awvalid), 256'(0));
    end else begin
      chk("arvalid", 256'(axi_arvalid), 256'(1));
      chk("araddr", 256'(axi_araddr), 256'(v.addr));
      chk("arlen", 256'(axi_arlen), 256'(v.len));
      chk("arid", 256'(axi_aruser_id), 256'(v.id));
      chk("arap", 256'(axi_aruser_ap), 256'(1));
      axi_arready = 1'b1;
      @(negedge core_clk);
      axi_arready = 1'b0;
      for (int k = 0; k <= int'(v.len); k++) begin
        w = v.w0 + 32'(k);
        axi_rvalid = 1'b1;
        axi_rdata  = (k == v.bad) ? {8{32'hDEADBEEF}} : {8{w}};
        axi_rid    = v.rid;
        axi_rlast  = !v.no_rlast && (k == int'(v.len));
        @(negedge core_clk);
      end
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      exp_err += v.dlt;
      chk("rd_done", 256'(done), 256'(1));
      chk("err_cnt", 256'(err_cnt), 256'(exp_err));
    end
    @(negedge core_clk);
    chk("done_pulse_once", 256'(done), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    bit bad;
    vec_t v;

    vecs[0] = '{1'b1, 28'h0000100, 4'd3, 4'd1, 2, 4'd0, -1, 1'b0, 0, 32'h00000100};
    vecs[1] = '{1'b0, 28'h0000100, 4'd3, 4'd2, 0, 4'd2, -1, 1'b0, 0, 32'h00000100};
    vecs[2] = '{1'b0, 28'h0000100, 4'd3, 4'd2, 0, 4'd2,  2, 1'b0, 1, 32'h00000100};
    vecs[3] = '{1'b0, 28'h0000100, 4'd3, 4'd2, 0, 4'd5, -1, 1'b0, 4, 32'h00000100};
    vecs[4] = '{1'b1, 28'hFFFFFFE, 4'd3, 4'd7, 0, 4'd0, -1, 1'b0, 0, 32'h0FFFFFFE};
    vecs[5] = '{1'b0, 28'h0000040, 4'd0, 4'd3, 0, 4'd3, -1, 1'b1, 1, 32'h00000040};
    vecs[6] = '{1'b0, 28'hABCDEF0, 4'd15, 4'd9, 0, 4'd9, 15, 1'b0, 1, 32'h0ABCDEF0};
    vecs[7] = '{1'b0, 28'h0000010, 4'd1, 4'd4, 0, 4'd6,  0, 1'b0, 2, 32'h00000010};
    vecs[8] = '{1'b1, 28'h0000020, 4'd15, 4'd0, 5, 4'd0, -1, 1'b0, 0, 32'h00000020};

    repeat (3) @(negedge core_clk);
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(0));
    chk("rst_awvalid", 256'(axi_awvalid), 256'(0));
    chk("rst_arvalid", 256'(axi_arvalid), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err_cnt", 256'(err_cnt), 256'(0));
    chk("rst_timeout", 256'(timeout), 256'(0));
    resetn = 1'b1;

    // commands blocked until calibration completes
    cmd_write = 1'b1;
    cmd_addr  = 28'h300;
    cmd_len   = 4'd0;
    cmd_id    = 4'd1;
    cmd_valid = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge core_clk);
      if (cmd_ready || axi_awvalid) bad = 1'b1;
    end
    chk("no_accept_before_init", 256'(bad), 256'(0));
    ddr_init_done = 1'b1;
    n = 0;
    while (!axi_awvalid && n < 10) begin
      @(negedge core_clk);
      n++;
    end
    chk("accept_within_2", 256'(n <= 2 && axi_awvalid), 256'(1));
    cmd_valid   = 1'b0;
    axi_awready = 1'b1;
    @(negedge core_clk);
    axi_awready = 1'b0;
    chk("init_wdata", axi_wdata, {8{32'h00000300}});
    axi_wready = 1'b1;
    @(negedge core_clk);
    axi_wready = 1'b0;
    chk("init_done", 256'(done), 256'(1));
    @(negedge core_clk);

    // stray read data while idle is ignored
    axi_rvalid = 1'b1;
    axi_rid    = 4'hF;
    axi_rlast  = 1'b1;
    axi_rdata  = {8{32'h12345678}};
    repeat (3) @(negedge core_clk);
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("idle_rvalid_ignored", 256'(err_cnt), 256'(exp_err));

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // address channel never answers
    issue(1'b1, 28'h500, 4'd1, 4'd2);
    n = 0;
    while (axi_awvalid && n < 100) begin
      n++;
      @(negedge core_clk);
    end
    chk("timeout_cycles", 256'(n), 256'(TO));
    chk("timeout_done", 256'(done), 256'(1));
    chk("timeout_flag", 256'(timeout), 256'(1));
    chk("timeout_idle", 256'(cmd_ready), 256'(1));
    @(negedge core_clk);
    chk("timeout_done_low", 256'(done), 256'(0));
    chk("timeout_sticky", 256'(timeout), 256'(1));

    // reset in the middle of a write data phase
    issue(1'b1, 28'h600, 4'd7, 4'd3);
    axi_awready = 1'b1;
    @(negedge core_clk);
    axi_awready = 1'b0;
    axi_wready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_wdata", axi_wdata, {8{32'h00000600 + 32'(k)}});
      if (k < 2) @(negedge core_clk);
    end
    resetn     = 1'b0;
    axi_wready = 1'b0;
    @(negedge core_clk);
    exp_err = 0;
    chk("mid_rst_awvalid", 256'(axi_awvalid), 256'(0));
    chk("mid_rst_arvalid", 256'(axi_arvalid), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    chk("mid_rst_err", 256'(err_cnt), 256'(0));
    chk("mid_rst_timeout", 256'(timeout), 256'(0));
    resetn = 1'b1;
    v = '{1'b1, 28'h0000700, 4'd2, 4'd5, 1, 4'd0, -1, 1'b0, 0, 32'h00000700};
    run_vec(v);
    v = '{1'b0, 28'h0000700, 4'd2, 4'd5, 0, 4'd5, -1, 1'b0, 0, 32'h00000700};
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
